// File: rtl/lut_pkg.sv
// Shared sizing helpers and constants for the cascaded LUT logic element.
package lut_pkg;

   // Value of the mode bit that selects the registered output path.
   localparam logic MODE_REG = 1'b1;

   // Configuration length: one 2**k-entry table per stage plus the mode bit.
   function automatic int cfg_bits(input int k, input int s);
      return s * (1 << k) + 1;
   endfunction

   // Address width: k bits for the first stage, k-1 fresh bits for each later stage.
   function automatic int addr_w(input int k, input int s);
      return k + (s - 1) * (k - 1);
   endfunction

endpackage

// File: rtl/lut_stage.sv
// Single K-input LUT: selects one bit of a 2**K-entry truth table.
module lut_stage #(
   parameter int K = 4
) (
   input  logic [(1 << K)-1:0] tbl_i,
   input  logic [K-1:0]        idx_i,
   output logic                y_o
);

   assign y_o = tbl_i[idx_i];

endmodule

// File: rtl/lut_sxx_chain.sv
// Cascaded K-input LUT chain with a serial daisy-chained configuration
// register, saturating load counter and a mode-selectable output register.
module lut_sxx_chain
   import lut_pkg::*;
#(
   parameter  int INPUTS   = 4,
   parameter  int STAGES   = 2,
   localparam int ADDR_W   = addr_w(INPUTS, STAGES),
   localparam int CFG_BITS = cfg_bits(INPUTS, STAGES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              config_en,
   input  logic              config_in,
   output logic              config_out,
   output logic              config_done,
   input  logic [ADDR_W-1:0] addr,
   input  logic              ce,
   output logic              out
);

   localparam int TBL   = 1 << INPUTS;
   localparam int CNT_W = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                q_q, q_d;
   logic [STAGES-1:0]   y;
   logic                comb;
   logic                mode;

   assign mode        = cfg_q[CFG_BITS-1];
   assign config_out  = cfg_q[CFG_BITS-1];
   assign config_done = (cnt_q == CNT_MAX);
   assign comb        = y[STAGES-1];

   // Stage 0 uses the top K address bits; each later stage puts the previous
   // stage result in the index MSB and takes the next K-1 address bits below it.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         lut_stage #(.K(INPUTS)) u_stage (
            .tbl_i (cfg_q[CFG_BITS-2-s*TBL -: TBL]),
            .idx_i (addr[ADDR_W-1 -: INPUTS]),
            .y_o   (y[s])
         );
      end else begin : g_next
         lut_stage #(.K(INPUTS)) u_stage (
            .tbl_i (cfg_q[CFG_BITS-2-s*TBL -: TBL]),
            .idx_i ({y[s-1], addr[ADDR_W-INPUTS-(s-1)*(INPUTS-1)-1 -: INPUTS-1]}),
            .y_o   (y[s])
         );
      end
   end

   // Next state: shift config and count loads; user register captures only
   // when fully configured and not being reconfigured.
   always_comb begin
      cfg_d = cfg_q;
      cnt_d = cnt_q;
      q_d   = q_q;
      if (config_en) begin
         cfg_d = {cfg_q[CFG_BITS-2:0], config_in};
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (ce && config_done) begin
         q_d = comb;
      end
   end

   // State registers with synchronous reset taking priority over all enables.
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q <= '0;
         cnt_q <= '0;
         q_q   <= 1'b0;
      end else begin
         cfg_q <= cfg_d;
         cnt_q <= cnt_d;
         q_q   <= q_d;
      end
   end

   // Output mux: combinational result or registered copy, per mode bit.
   always_comb begin
      out = comb;
      if (mode == MODE_REG) begin
         out = q_q;
      end
   end

endmodule

// File: tb/tb_lut_sxx_chain.sv
// Directed self-checking bench for lut_sxx_chain (INPUTS=4, STAGES=2).
module tb_lut_sxx_chain;

   localparam int K  = 4;
   localparam int S  = 2;
   localparam int CB = 33;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic          config_en;
   logic          config_in;
   logic          config_out;
   logic          config_done;
   logic [AW-1:0] addr;
   logic          ce;
   logic          out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lut_sxx_chain #(.INPUTS(K), .STAGES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .config_en   (config_en),
      .config_in   (config_in),
      .config_out  (config_out),
      .config_done (config_done),
      .addr        (addr),
      .ce          (ce),
      .out         (out)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic shift_bit(input logic b);
      config_in = b;
      config_en = 1'b1;
      tick();
      config_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; config_en = 1'b1; config_in = 1'b1; ce = 1'b1; addr = '0;
      tick();
      tick();
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL reset_out: got %b expected 0", out);
      end
      checks++;
      if (config_out !== 1'b0) begin
         failures++; $display("FAIL reset_config_out: got %b expected 0", config_out);
      end
      checks++;
      if (config_done !== 1'b0) begin
         failures++; $display("FAIL reset_done: got %b expected 0", config_done);
      end
      rst = 1'b0; config_en = 1'b0; config_in = 1'b0; ce = 1'b0;
   endtask

   task automatic test_comb_load;
      logic [32:0] v;
      v = {1'b0, 16'h8000, 16'hFF00};
      for (int i = 32; i >= 0; i--) begin
         shift_bit(v[i]);
         checks++;
         if (config_done !== (i == 0)) begin
            failures++;
            $display("FAIL comb_done_step%0d: got %b expected %b", 32 - i, config_done, (i == 0));
         end
      end
      checks++;
      if (config_out !== 1'b0) begin
         failures++; $display("FAIL comb_config_out: got %b expected 0", config_out);
      end
      addr = 7'b1111000; #1;
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL comb_1111000: got %b expected 1", out);
      end
      addr = 7'b1110000; #1;
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL comb_1110000: got %b expected 0", out);
      end
      addr = 7'b1111111; #1;
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL comb_1111111: got %b expected 1", out);
      end
      addr = 7'b0111000; #1;
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL comb_0111000: got %b expected 0", out);
      end
   endtask

   task automatic test_registered;
      logic [32:0] v;
      v = {1'b1, 16'h8000, 16'hFF00};
      for (int i = 32; i >= 0; i--) shift_bit(v[i]);
      addr = 7'b1111000; #1;
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL reg_initial_q: got %b expected 0", out);
      end
      ce = 1'b1;
      tick();
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL reg_capture1: got %b expected 1", out);
      end
      addr = 7'b0000000; #1;
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL reg_latency: got %b expected 1", out);
      end
      tick();
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL reg_capture0: got %b expected 0", out);
      end
      addr = 7'b1111000;
      tick();
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL reg_capture1b: got %b expected 1", out);
      end
      ce = 1'b0; addr = 7'b0000000;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out !== 1'b1) begin
            failures++; $display("FAIL reg_hold_cycle%0d: got %b expected 1", c, out);
         end
      end
   endtask

   task automatic test_daisy;
      logic [65:0] p;
      logic        sent [66];
      logic        exp_o;
      int          k;
      p = {2'b10, 64'hA5A5A5A5A5A5A5A5};
      rst = 1'b1; tick(); rst = 1'b0;
      k = 0;
      for (int i = 65; i >= 0; i--) begin
         sent[k] = p[i];
         shift_bit(p[i]);
         k++;
         exp_o = (k >= CB) ? sent[k-CB] : 1'b0;
         checks++;
         if (config_out !== exp_o) begin
            failures++; $display("FAIL daisy_shift%0d: got %b expected %b", k, config_out, exp_o);
         end
         if (k == 40) begin
            for (int c = 0; c < 5; c++) begin
               config_in = ~config_in;
               tick();
               checks++;
               if (config_out !== exp_o) begin
                  failures++; $display("FAIL daisy_pause%0d: got %b expected %b", c, config_out, exp_o);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [32:0] v;
      v = {1'b0, 16'h0001, 16'hFF00};
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 10; i++) shift_bit(1'b1);
      rst = 1'b1; config_en = 1'b1; config_in = 1'b1;
      tick();
      rst = 1'b0; config_en = 1'b0;
      checks++;
      if (config_done !== 1'b0 || config_out !== 1'b0) begin
         failures++;
         $display("FAIL mid_after_rst: got done=%b cout=%b expected done=0 cout=0", config_done, config_out);
      end
      for (int i = 32; i >= 1; i--) shift_bit(v[i]);
      checks++;
      if (config_done !== 1'b0) begin
         failures++; $display("FAIL mid_done_32: got %b expected 0", config_done);
      end
      shift_bit(v[0]);
      checks++;
      if (config_done !== 1'b1) begin
         failures++; $display("FAIL mid_done_33: got %b expected 1", config_done);
      end
      addr = 7'b0000000; #1;
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL mid_0000000: got %b expected 1", out);
      end
      addr = 7'b1111000; #1;
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL mid_1111000: got %b expected 0", out);
      end
      addr = 7'b0001111; #1;
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL mid_0001111: got %b expected 0", out);
      end
   endtask

   task automatic test_reconfig;
      logic [32:0] v2;
      v2 = {1'b1, 16'h0001, 16'h00FF};
      for (int i = 0; i < CB; i++) shift_bit(1'b1);
      addr = 7'b0000000; ce = 1'b1;
      tick();
      checks++;
      if (out !== 1'b1) begin
         failures++; $display("FAIL recfg_q_set: got %b expected 1", out);
      end
      for (int i = 32; i >= 0; i--) begin
         shift_bit(v2[i]);
         checks++;
         if (out !== 1'b1 || config_done !== 1'b1) begin
            failures++;
            $display("FAIL recfg_hold_step%0d: got out=%b done=%b expected out=1 done=1", 32 - i, out, config_done);
         end
      end
      tick();
      checks++;
      if (out !== 1'b0) begin
         failures++; $display("FAIL recfg_update: got %b expected 0", out);
      end
      ce = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; config_en = 1'b0; config_in = 1'b0; ce = 1'b0; addr = '0;
      test_reset();
      test_comb_load();
      test_registered();
      test_daisy();
      test_reset_mid();
      test_reconfig();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
